// File: rtl/fly_path_animator.sv
// Sprite fly-path animator: draws a sprite, holds, erases and steps it one column at a time
// until it lands on target_x or would leave the screen. Define FLY_BG_RESTORE_EN to erase from background ROM.
module fly_path_animator #(
  parameter int          SPRITE_W      = 4,
  parameter int          SPRITE_H      = 4,
  parameter int          HOLD_CYCLES   = 150000,
  parameter int          SCREEN_W      = 320,
  parameter logic [2:0]  SPRITE_COLOUR = 3'b000,
  parameter logic [2:0]  ERASE_COLOUR  = 3'b111
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        dir,
  input  logic [8:0]  start_x,
  input  logic [7:0]  start_y,
  input  logic [8:0]  target_x,
  output logic [8:0]  x,
  output logic [7:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic [16:0] bg_addr,
  input  logic [2:0]  bg_colour,
  output logic        busy,
  output logic        over,
  output logic        hit
);

  localparam int NPIX = SPRITE_W * SPRITE_H;
  localparam int PW   = $clog2(NPIX + 1);
  localparam int HW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
`ifdef FLY_BG_RESTORE_EN
  localparam int ELAST = NPIX;
`else
  localparam int ELAST = NPIX - 1;
`endif
  localparam logic [PW-1:0] P_LAST_DRAW  = PW'(NPIX - 1);
  localparam logic [PW-1:0] P_LAST_ERASE = PW'(ELAST);
  localparam logic [HW-1:0] H_LAST       = HW'(HOLD_CYCLES - 1);
  localparam logic [9:0]    X_MAX        = 10'(SCREEN_W - SPRITE_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_HOLD,
    S_CHECK,
    S_ERASE,
    S_STEP,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [8:0]    pos_x_q, pos_x_d;
  logic [7:0]    pos_y_q, pos_y_d;
  logic          dir_q, dir_d;
  logic [8:0]    tgt_q, tgt_d;
  logic [PW-1:0] p_q, p_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          over_q, over_d;
  logic          hit_q, hit_d;

  logic [9:0]    next_x;
  logic [8:0]    addr_x;
  logic [7:0]    addr_y;

  // Pixel index to offset within the sprite, row-major
  function automatic logic [8:0] off_x(input logic [PW-1:0] i);
    return 9'(32'(i) % SPRITE_W);
  endfunction

  function automatic logic [7:0] off_y(input logic [PW-1:0] i);
    return 8'(32'(i) / SPRITE_W);
  endfunction

`ifndef FLY_BG_RESTORE_EN
  logic unused_bg;
  assign unused_bg = ^bg_colour;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      pos_x_q <= '0;
      pos_y_q <= '0;
      dir_q   <= 1'b0;
      tgt_q   <= '0;
      p_q     <= '0;
      hold_q  <= '0;
      over_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      dir_q   <= dir_d;
      tgt_q   <= tgt_d;
      p_q     <= p_d;
      hold_q  <= hold_d;
      over_q  <= over_d;
      hit_q   <= hit_d;
    end
  end

  // Zero-extended so a leftward step from column 0 lands far above X_MAX instead of wrapping
  assign next_x = dir_q ? ({1'b0, pos_x_q} - 10'd1) : ({1'b0, pos_x_q} + 10'd1);

  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    dir_d   = dir_q;
    tgt_d   = tgt_q;
    p_d     = p_q;
    hold_d  = hold_q;
    over_d  = over_q;
    hit_d   = hit_q;
    x       = '0;
    y       = '0;
    colour  = '0;
    plot    = 1'b0;
    bg_addr = '0;
    addr_x  = '0;
    addr_y  = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pos_x_d = start_x;
          pos_y_d = start_y;
          dir_d   = dir;
          tgt_d   = target_x;
          over_d  = 1'b0;
          hit_d   = 1'b0;
          p_d     = '0;
          hold_d  = '0;
          state_d = S_DRAW;
        end
      end

      S_DRAW: begin
        plot   = 1'b1;
        x      = pos_x_q + off_x(p_q);
        y      = pos_y_q + off_y(p_q);
        colour = SPRITE_COLOUR;
        if (p_q == P_LAST_DRAW) begin
          p_d     = '0;
          state_d = S_HOLD;
        end else begin
          p_d = p_q + PW'(1);
        end
      end

      S_HOLD: begin
        if (hold_q == H_LAST) begin
          hold_d  = '0;
          state_d = S_CHECK;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end

      S_CHECK: begin
        if (pos_x_q == tgt_q) begin
          over_d  = 1'b1;
          hit_d   = 1'b1;
          state_d = S_DONE;
        end else if (next_x > X_MAX) begin
          over_d  = 1'b1;
          hit_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          p_d     = '0;
          state_d = S_ERASE;
        end
      end

      S_ERASE: begin
`ifdef FLY_BG_RESTORE_EN
        // Address pixel p now; the ROM answers next cycle, when pixel p-1 is plotted
        if (p_q != P_LAST_ERASE) begin
          addr_x  = pos_x_q + off_x(p_q);
          addr_y  = pos_y_q + off_y(p_q);
          bg_addr = 17'(32'(addr_y) * SCREEN_W + 32'(addr_x));
        end
        if (p_q != '0) begin
          plot   = 1'b1;
          x      = pos_x_q + off_x(p_q - PW'(1));
          y      = pos_y_q + off_y(p_q - PW'(1));
          colour = bg_colour;
        end
`else
        plot   = 1'b1;
        x      = pos_x_q + off_x(p_q);
        y      = pos_y_q + off_y(p_q);
        colour = ERASE_COLOUR;
`endif
        if (p_q == P_LAST_ERASE) begin
          p_d     = '0;
          state_d = S_STEP;
        end else begin
          p_d = p_q + PW'(1);
        end
      end

      S_STEP: begin
        pos_x_d = next_x[8:0];
        p_d     = '0;
        state_d = S_DRAW;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign over = over_q;
  assign hit  = hit_q;

endmodule

// File: doc/fly_path_animator.md
FLY_PATH_ANIMATOR -- requirements
Module: fly_path_animator

Interface
REQ-001 Parameter SPRITE_W, default 4: sprite width in pixels, power of 2, 1..16.
REQ-002 Parameter SPRITE_H, default 4: sprite height in pixels, power of 2, 1..16.
REQ-003 Parameter HOLD_CYCLES, default 150000: clocks per HOLD state, at least 1.
REQ-004 Parameter SCREEN_W, default 320: screen width in pixels, also the background row stride.
REQ-005 Parameter SPRITE_COLOUR, default 3'b000; parameter ERASE_COLOUR, default 3'b111.
REQ-006 Port clock, input, 1: CLOCK_50; the only clock.
REQ-007 Port resetn, input, 1: reset, asynchronous, active-low.
REQ-008 Port start, input, 1: single-cycle launch pulse.
REQ-009 Port dir, input, 1: 0 moves rightward (x+1 per step), 1 moves leftward (x-1 per step); sampled on accepted start.
REQ-010 Ports start_x, input, 9, and start_y, input, 8: initial sprite top-left corner; sampled on accepted start.
REQ-011 Port target_x, input, 9: landing column; sampled on accepted start.
REQ-012 Ports x, output, 9; y, output, 8; colour, output, 3; plot, output, 1: VGA write port.
REQ-013 Port bg_addr, output, 17: background ROM address, y*SCREEN_W+x.
REQ-014 Port bg_colour, input, 3: ROM data, valid one clock after bg_addr.
REQ-015 Ports busy, output, 1; over, output, 1; hit, output, 1: status.

Function
REQ-016 States: IDLE, DRAW, HOLD, CHECK, ERASE, STEP, DONE.
REQ-017 start is accepted in IDLE or DONE; it latches the inputs into pos_x, pos_y, dir_q and tgt_q, clears over and hit, and enters DRAW. start is ignored in all other states.
REQ-018 DRAW: pixel counter p runs 0..SPRITE_W*SPRITE_H-1, one pixel per clock, with plot=1, x=pos_x+(p mod SPRITE_W), y=pos_y+(p/SPRITE_W) and colour=SPRITE_COLOUR. DRAW then goes to HOLD.
REQ-019 HOLD lasts exactly HOLD_CYCLES clocks with plot=0, then goes to CHECK.
REQ-020 CHECK lasts one clock: if pos_x==tgt_q, go to DONE with hit=1; else if the next step would leave [0, SCREEN_W-SPRITE_W], go to DONE with hit=0; otherwise go to ERASE.
REQ-021 ERASE lasts SPRITE_W*SPRITE_H+1 clocks. Cycle k presents bg_addr for pixel k. Cycle k+1 plots pixel k with colour=bg_colour. Cycle 0 has plot=0.
REQ-022 STEP lasts one clock: pos_x moves one column in dir_q, pos_y is unchanged, then go to DRAW.
REQ-023 DONE: over=1 and hit are held, plot=0, and the sprite stays drawn until an accepted start.
REQ-024 busy=1 in every state except IDLE and DONE.
REQ-025 plot=0 in IDLE, HOLD, CHECK, STEP and DONE.
REQ-026 x, y and bg_addr arithmetic is unsigned and truncated to port width. Callers keep start_y+SPRITE_H below 240.
REQ-027 A target_x that is never reached ends at the boundary stop of REQ-020 and never wraps.
REQ-028 start_x==target_x gives one DRAW pass, then DONE with hit=1.

Reset
REQ-029 resetn low, at any time including mid-DRAW or mid-ERASE, forces IDLE, pos_x=0, pos_y=0, p=0, the hold counter to 0, and x=0, y=0, colour=0, plot=0, bg_addr=0, busy=0, over=0, hit=0.
REQ-030 After resetn rises, no pixel is plotted until the next accepted start.

Configuration
REQ-031 Macro FLY_BG_RESTORE_EN defined: ERASE behaves as REQ-021, restoring pixels from background ROM data.
REQ-032 Macro FLY_BG_RESTORE_EN undefined: ERASE lasts SPRITE_W*SPRITE_H clocks, plots every cycle with colour=ERASE_COLOUR, bg_addr is held at 0, and bg_colour is unused.

Verification (SPRITE_W=SPRITE_H=4, HOLD_CYCLES=3)
REQ-033 Rightward hit: start_x=0, start_y=165, target_x=2, dir=0. Required: DRAW passes at x=0, 1, 2; 2 ERASE passes; 80 plot cycles; over=1, hit=1; final pixels at x 2..5, y 165..168.
REQ-034 Leftward boundary miss: start_x=2, target_x=9, dir=1. Required: DRAW passes at x=2, 1, 0; then over=1, hit=0; pos_x never wraps to 511.
REQ-035 Erase latency: bg_colour driven as a function of the bg_addr registered the previous cycle. Required: each ERASE plot at (x, y) carries the value for address y*320+x; cycle 0 of ERASE has plot=0.
REQ-036 Reset mid-operation: resetn pulsed low during the 7th ERASE cycle. Required: plot, busy and over are 0 immediately; the state stays IDLE until start.
REQ-037 start held during DRAW and HOLD is ignored. start in DONE relaunches with the new inputs and clears over the next cycle.
REQ-038 FLY_BG_RESTORE_EN undefined: ERASE passes are 16 cycles with colour=3'b111 and bg_addr=0.
